// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester adder arbiter.
// Contents:
//   WIDTH_DEF : default operand/result width, matching the adder
//   state_t   : arbiter FSM encoding (2'd3 is unused and recovers to IDLE)
package alu_arbiter_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Registered adder shared by the arbiter clients.
// Ports:
//   Clk   in          : rising-edge clock
//   Clear in          : asynchronous, active-high clear of the sum register
//   Data1 in  [WIDTH] : first operand
//   Data2 in  [WIDTH] : second operand
//   Sum   out [WIDTH] : registered (Data1 + Data2) mod 2^WIDTH, no carry out
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic [WIDTH-1:0] Data1,
  input  logic [WIDTH-1:0] Data2,
  output logic [WIDTH-1:0] Sum
);

  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      Sum <= '0;
    end else begin
      Sum <= Data1 + Data2;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered adder between requesters A and B.
// A grant captures the winner's operands; the adder registers the sum one edge
// later, and the sum is presented on Result with a one-cycle Done strobe.
// Ports:
//   Clk, nClear          : clock, asynchronous active-low reset
//   ReqA, A1, A2         : requester A level request and operands
//   ReqB, B1, B2         : requester B level request and operands
//   GntA, GntB           : registered grants, held through the Done cycle
//   DoneA, DoneB         : one-cycle completion strobes
//   Result [WIDTH]       : adder sum, holds between operations
//   Busy                 : high while in ISSUE or DONE
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             nClear,
  input  logic             ReqA,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic             ReqB,
  input  logic [WIDTH-1:0] B1,
  input  logic [WIDTH-1:0] B2,
  output logic             GntA,
  output logic             GntB,
  output logic             DoneA,
  output logic             DoneB,
  output logic [WIDTH-1:0] Result,
  output logic             Busy
);

  state_t           state;
  state_t           state_nx;
  logic             ptr_b;      // 1: B wins a tie, 0: A wins a tie
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;

  logic             arb_edge;
  logic             win_a;
  logic             win_b;
  logic             gnt_a_nx;
  logic             gnt_b_nx;
  logic             done_a_nx;
  logic             done_b_nx;

  // Arbitration only takes place on edges leaving IDLE or DONE; in ISSUE
  // the request inputs are ignored entirely.
  assign arb_edge = (state == IDLE) || (state == DONE);
  assign win_a    = arb_edge && ReqA && (!ReqB || !ptr_b);
  assign win_b    = arb_edge && ReqB && (!ReqA ||  ptr_b);

  // State register
  always_ff @(posedge Clk or negedge nClear) begin
    if (!nClear) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = (ReqA || ReqB) ? ISSUE : IDLE;
      ISSUE:   state_nx = DONE;
      DONE:    state_nx = (ReqA || ReqB) ? ISSUE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode: the values the output registers take on the coming edge
  always_comb begin
    gnt_a_nx  = 1'b0;
    gnt_b_nx  = 1'b0;
    done_a_nx = 1'b0;
    done_b_nx = 1'b0;
    case (state)
      IDLE, DONE: begin
        gnt_a_nx = win_a;
        gnt_b_nx = win_b;
      end
      ISSUE: begin
        // Grant is held into the Done cycle; the sum lands on this edge.
        gnt_a_nx  = GntA;
        gnt_b_nx  = GntB;
        done_a_nx = GntA;
        done_b_nx = GntB;
      end
      default: ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge Clk or negedge nClear) begin
    if (!nClear) begin
      GntA  <= 1'b0;
      GntB  <= 1'b0;
      DoneA <= 1'b0;
      DoneB <= 1'b0;
      Busy  <= 1'b0;
    end else begin
      GntA  <= gnt_a_nx;
      GntB  <= gnt_b_nx;
      DoneA <= done_a_nx;
      DoneB <= done_b_nx;
      Busy  <= (state_nx != IDLE);
    end
  end

  // Operand capture and pointer update on the grant edge. The operand
  // registers are cleared too, otherwise the free-running adder would
  // recompute a stale sum onto Result after reset without any Done.
  always_ff @(posedge Clk or negedge nClear) begin
    if (!nClear) begin
      ptr_b <= 1'b0;
      op1   <= '0;
      op2   <= '0;
    end else if (win_a) begin
      ptr_b <= 1'b1;
      op1   <= A1;
      op2   <= A2;
    end else if (win_b) begin
      ptr_b <= 1'b0;
      op1   <= B1;
      op2   <= B2;
    end
  end

  // The adder loads every cycle, but its inputs only change on a grant, so
  // its output moves exactly on the edge that raises Done and holds after.
  alu #(.WIDTH(WIDTH)) u_alu (
    .Clk   (Clk),
    .Clear (!nClear),
    .Data1 (op1),
    .Data2 (op2),
    .Sum   (Result)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic       Clk    = 1'b0;
  logic       nClear = 1'b1;
  logic       ReqA   = 1'b0;
  logic       ReqB   = 1'b0;
  logic [7:0] A1     = 8'h00;
  logic [7:0] A2     = 8'h00;
  logic [7:0] B1     = 8'h00;
  logic [7:0] B2     = 8'h00;
  logic       GntA, GntB, DoneA, DoneB, Busy;
  logic [7:0] Result;

  int n_vec = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  alu_arbiter #(.WIDTH(8)) dut (
    .Clk    (Clk),
    .nClear (nClear),
    .ReqA   (ReqA),
    .A1     (A1),
    .A2     (A2),
    .ReqB   (ReqB),
    .B1     (B1),
    .B2     (B2),
    .GntA   (GntA),
    .GntB   (GntB),
    .DoneA  (DoneA),
    .DoneB  (DoneB),
    .Result (Result),
    .Busy   (Busy)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b, want %b", name, $time, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level reference: who owns the adder, how far along the
  // current operation is (0 = first cycle after grant, 1 = completion cycle),
  // who wins the next tie, and the last completed sum.
  int         m_owner;   // 0 none, 1 A, 2 B
  int         m_age;
  logic       m_favor_b;
  logic [7:0] m_sum;
  logic [7:0] m_res;

  always @(posedge Clk or negedge nClear) begin
    if (!nClear) begin
      m_owner   <= 0;
      m_age     <= 0;
      m_favor_b <= 1'b0;
      m_res     <= 8'h00;
    end else if (m_owner != 0 && m_age == 0) begin
      m_age <= 1;
      m_res <= m_sum;
    end else begin
      // adder is free (idle or completing): pick the next owner
      if (ReqA && (!ReqB || !m_favor_b)) begin
        m_owner <= 1; m_age <= 0; m_sum <= A1 + A2; m_favor_b <= 1'b1;
      end else if (ReqB) begin
        m_owner <= 2; m_age <= 0; m_sum <= B1 + B2; m_favor_b <= 1'b0;
      end else begin
        m_owner <= 0; m_age <= 0;
      end
    end
  end

  logic exp_gnt_a, exp_gnt_b, exp_done_a, exp_done_b, exp_busy;
  assign exp_gnt_a  = (m_owner == 1);
  assign exp_gnt_b  = (m_owner == 2);
  assign exp_done_a = (m_owner == 1) && (m_age == 1);
  assign exp_done_b = (m_owner == 2) && (m_age == 1);
  assign exp_busy   = (m_owner != 0);

  // Every-cycle comparison against the reference
  always @(negedge Clk) begin
    chk1("m_gnt_a",  GntA,  exp_gnt_a);
    chk1("m_gnt_b",  GntB,  exp_gnt_b);
    chk1("m_done_a", DoneA, exp_done_a);
    chk1("m_done_b", DoneB, exp_done_b);
    chk1("m_busy",   Busy,  exp_busy);
    chk8("m_result", Result, m_res);
  end

  initial begin
    // Asynchronous reset with no clock edge
    #1 nClear = 1'b0;
    #2;
    chk1("rst_gnt_a", GntA, 1'b0);
    chk1("rst_gnt_b", GntB, 1'b0);
    chk1("rst_done",  DoneA | DoneB, 1'b0);
    chk1("rst_busy",  Busy, 1'b0);
    chk8("rst_result", Result, 8'h00);
    @(negedge Clk);
    @(negedge Clk);
    nClear = 1'b1;

    // Single request from A: 12 + 34
    ReqA = 1'b1; A1 = 8'h12; A2 = 8'h34;
    @(negedge Clk);
    chk1("single_gnt", GntA, 1'b1);
    chk1("single_busy", Busy, 1'b1);
    chk1("single_nodone", DoneA, 1'b0);
    @(negedge Clk);
    chk1("single_done", DoneA, 1'b1);
    chk8("single_res", Result, 8'h46);
    chk8("single_model", m_res, 8'h46);
    ReqA = 1'b0;
    @(negedge Clk);
    chk1("single_idle_busy", Busy, 1'b0);
    chk1("single_done_low", DoneA, 1'b0);
    chk8("single_res_hold", Result, 8'h46);

    // Carry discarded: F0 + 20
    ReqB = 1'b1; B1 = 8'hF0; B2 = 8'h20;
    @(negedge Clk);
    chk1("wrap_gnt", GntB, 1'b1);
    @(negedge Clk);
    chk1("wrap_done", DoneB, 1'b1);
    chk8("wrap_res", Result, 8'h10);
    ReqB = 1'b0;
    @(negedge Clk);

    // Operand isolation: inputs changed after the grant edge
    ReqA = 1'b1; A1 = 8'h05; A2 = 8'h06;
    @(negedge Clk);
    A1 = 8'hFF; A2 = 8'hFF;
    @(negedge Clk);
    chk1("iso_done", DoneA, 1'b1);
    chk8("iso_res", Result, 8'h0B);
    ReqA = 1'b0;
    @(negedge Clk);

    // Early withdrawal: B pulses between edges while A is in ISSUE
    ReqA = 1'b1; A1 = 8'h10; A2 = 8'h01;
    @(negedge Clk);
    #1 ReqB = 1'b1;
    #2 ReqB = 1'b0;
    @(negedge Clk);
    chk1("wd_done_a", DoneA, 1'b1);
    chk1("wd_gnt_b", GntB, 1'b0);
    chk8("wd_res", Result, 8'h11);
    ReqA = 1'b0;
    @(negedge Clk);
    chk1("wd_gnt_b2", GntB, 1'b0);
    chk1("wd_done_b", DoneB, 1'b0);
    chk1("wd_busy", Busy, 1'b0);

    // Reset during ISSUE of A (3 + 4), request kept high across reset
    ReqA = 1'b1; A1 = 8'h03; A2 = 8'h04;
    @(posedge Clk);
    #2;
    chk1("rmid_gnt_before", GntA, 1'b1);
    nClear = 1'b0;
    #1;
    chk1("rmid_gnt", GntA, 1'b0);
    chk1("rmid_busy", Busy, 1'b0);
    chk1("rmid_done", DoneA, 1'b0);
    chk8("rmid_res", Result, 8'h00);
    @(negedge Clk);
    chk1("rmid_nodone", DoneA, 1'b0);
    nClear = 1'b1;
    @(negedge Clk);
    chk1("rmid_regnt", GntA, 1'b1);
    @(negedge Clk);
    chk1("rmid_done2", DoneA, 1'b1);
    chk8("rmid_res2", Result, 8'h07);
    ReqA = 1'b0;
    @(negedge Clk);

    // Fresh reset so the pointer favours A, then both request continuously
    nClear = 1'b0;
    #2 nClear = 1'b1;
    ReqA = 1'b1; A1 = 8'h01; A2 = 8'h01;
    ReqB = 1'b1; B1 = 8'h02; B2 = 8'h02;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      chk1("rr_gnt_a",  GntA,  (k % 4 == 1) || (k % 4 == 2));
      chk1("rr_gnt_b",  GntB,  (k % 4 == 3) || (k % 4 == 0));
      chk1("rr_done_a", DoneA, (k % 4 == 2));
      chk1("rr_done_b", DoneB, (k % 4 == 0));
      if (k % 4 == 2) chk8("rr_res_a", Result, 8'h02);
      if (k % 4 == 0) chk8("rr_res_b", Result, 8'h04);
    end
    ReqA = 1'b0; ReqB = 1'b0;
    @(negedge Clk);

    // Randomised traffic against the reference, with occasional resets
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge Clk);
      if (!ReqA) begin
        if ($urandom_range(2) == 0) begin
          ReqA = 1'b1; A1 = 8'($urandom); A2 = 8'($urandom);
        end
      end else if (exp_done_a) begin
        if ($urandom_range(1) == 1) begin
          A1 = 8'($urandom); A2 = 8'($urandom);
        end else begin
          ReqA = 1'b0;
        end
      end else if ($urandom_range(3) == 0) begin
        A1 = 8'($urandom); A2 = 8'($urandom);
      end
      if (!ReqB) begin
        if ($urandom_range(2) == 0) begin
          ReqB = 1'b1; B1 = 8'($urandom); B2 = 8'($urandom);
        end
      end else if (exp_done_b) begin
        if ($urandom_range(1) == 1) begin
          B1 = 8'($urandom); B2 = 8'($urandom);
        end else begin
          ReqB = 1'b0;
        end
      end else if ($urandom_range(3) == 0) begin
        B1 = 8'($urandom); B2 = 8'($urandom);
      end
      if ($urandom_range(79) == 0) begin
        #3 nClear = 1'b0;
        #1 nClear = 1'b1;
      end
    end
    ReqA = 1'b0; ReqB = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
